hack_pc_sequencer: RTL and testbench
====================================

Name: hack_pc_sequencer

Overview:
- Multi-cycle fetch/execute sequencer for the Hack CPU.
- Drives the program counter's reset/load/increment controls and fetches instructions from ROM over a req/ack handshake.
- Evaluates the C-instruction jump condition and issues a one-cycle execute strobe to the datapath.
- Supports free-run and single-step modes, and halts on the canonical Hack end-of-program self-loop.

Parameters:
- ADDR_W, 15, PC/ROM address width.
- DATA_W, 16, instruction width.
- CNT_W, 16, retired-instruction counter width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = free-run.
- step  input  1  single-step request; rising-edge detected internally.
- rom_req  output  1  instruction fetch request.
- rom_ack  input  1  ROM data valid this cycle.
- rom_data  input  DATA_W  instruction word.
- pc_out  input  ADDR_W  current PC value (from pc).
- a_reg  input  ADDR_W  A-register value (jump target).
- alu_zr  input  1  ALU zero flag for the instruction in ir; combinational, valid during EXEC.
- alu_ng  input  1  ALU negative flag for the instruction in ir; combinational, valid during EXEC.
- ir  output  DATA_W  instruction register.
- exec_en  output  1  one-cycle commit strobe for A/D/M writes.
- pc_reset  output  1  pc reset control.
- pc_load  output  1  pc load control.
- pc_inc  output  1  pc increment control.
- pc_in  output  ADDR_W  pc load value; equals a_reg.
- busy  output  1  sequencer in INIT, FETCH or EXEC.
- halted  output  1  self-loop detected.
- instr_count  output  CNT_W  retired instructions.

Behaviour:
- **Reset (asynchronous):**
  - state = INIT, ir = 0, instr_count = 0, halted = 0, step_d = 0.
  - rom_req, exec_en, pc_reset, pc_load and pc_inc are all 0 immediately, including when reset asserts mid-fetch.
- **States:** INIT, IDLE, FETCH, EXEC, HALT. Registered state; outputs decoded from state, ir and inputs.
- **INIT:**
  - pc_reset = 1 for exactly one cycle (first clock after reset deasserts).
  - Next state = IDLE.
- **IDLE:**
  - If run = 1, go to FETCH.
  - Else if step rises (step = 1, step_d = 0), go to FETCH.
  - Else stay.
  - step_d <= step every cycle in every state.
- **FETCH:**
  - rom_req = 1 every cycle in FETCH.
  - On rom_ack = 1: ir <= rom_data, go to EXEC.
  - Without ack, wait indefinitely; no timeout.
  - Minimum latency IDLE->EXEC is 2 cycles (ack in the first FETCH cycle).
- **EXEC (exactly one cycle):**
  - exec_en = 1.
  - instr_count <= instr_count + 1; wraps modulo 2^CNT_W.
  - A-instruction (ir[15] = 0): pc_inc = 1.
  - C-instruction (ir[15] = 1): compute taken from j = ir[2:0]:
    - 000 never; 001 !zr & !ng; 010 zr; 011 !ng
    - 100 ng; 101 !zr; 110 zr | ng; 111 always
  - taken: pc_load = 1, pc_in = a_reg. Not taken: pc_inc = 1.
- **Exit from EXEC:**
  - If taken and a_reg == pc_out: go to HALT.
  - Else if run = 1: go to FETCH.
  - Else: go to IDLE.
  - run dropping during FETCH lets the current instruction complete, then goes to IDLE.
- **HALT:**
  - halted = 1; all strobes 0.
  - Exit only via reset; run and step are ignored.
- **Control exclusivity:** at most one of pc_reset/pc_load/pc_inc is 1 in any cycle, and only in INIT or EXEC.
- **step while run = 1:** no effect.
- **step held high:** produces one instruction only.
- **Status outputs:**
  - busy = (state != IDLE) & (state != HALT).
  - pc_in = a_reg combinationally at all times.

Test Plan:
- **Reset/init:** reset = 1 for 3 cycles, then release.
  - Required: pc_reset = 1 for exactly 1 cycle, then IDLE.
  - Required: busy = 0, instr_count = 0, ir = 0000.
- **Free-run A-instructions:** run = 1; ROM acks in the same cycle with 0x0005, 0x0007.
  - Required: exec_en pulses every 2nd cycle; pc_inc = 1 in each EXEC.
  - Required: ir = 0005 then 0007; instr_count = 2.
- **Jump table:** C-instruction 0xE301 (JGT) with zr = 0, ng = 0, a_reg = 0x0010, pc_out = 0x0004.
  - Required: pc_load = 1, pc_in = 0010.
  - Repeat for all 8 jump codes × flag combos {zr=1,ng=0}, {0,1}, {0,0}: pc_load/pc_inc match the truth table.
- **Handshake stall and run drop:** rom_ack delayed 4 cycles; run dropped during FETCH.
  - Required: rom_req held 5 cycles; one EXEC; state returns to IDLE.
- **Single-step:** run = 0, step held high for 6 cycles.
  - Required: exactly one exec_en pulse.
  - Required: a second step rising edge gives one more pulse; step with run = 1 is ignored.
- **Halt and async reset:**
  - 0xEA87 (0;JMP) with a_reg = pc_out = 0x0012: required halted = 1 and no further rom_req.
  - reset asserted mid-FETCH: required rom_req falls in the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/hack_pc_sequencer.sv
// ============================================================================
// Module      : hack_pc_sequencer
// Description : Hack CPU fetch/execute sequencer with ROM req/ack handshake,
//               jump evaluation, single-step mode and self-loop halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hack_pc_sequencer #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic              step,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [DATA_W-1:0] rom_data,
    input  logic [ADDR_W-1:0] pc_out,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic              alu_zr,
    input  logic              alu_ng,
    output logic [DATA_W-1:0] ir,
    output logic              exec_en,
    output logic              pc_reset,
    output logic              pc_load,
    output logic              pc_inc,
    output logic [ADDR_W-1:0] pc_in,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count
);

    localparam logic [2:0] c_st_init  = 3'd0;
    localparam logic [2:0] c_st_idle  = 3'd1;
    localparam logic [2:0] c_st_fetch = 3'd2;
    localparam logic [2:0] c_st_exec  = 3'd3;
    localparam logic [2:0] c_st_halt  = 3'd4;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [DATA_W-1:0] r_ir;
    logic [CNT_W-1:0]  r_count;
    logic              r_step_d;
    logic              w_cond;
    logic              w_taken;
    logic              w_active;
    logic              w_exec;

    always_comb begin
        w_cond = 1'b0;
        case (r_ir[2:0])
            3'b000:  w_cond = 1'b0;
            3'b001:  w_cond = !alu_zr && !alu_ng;
            3'b010:  w_cond = alu_zr;
            3'b011:  w_cond = !alu_ng;
            3'b100:  w_cond = alu_ng;
            3'b101:  w_cond = !alu_zr;
            3'b110:  w_cond = alu_zr || alu_ng;
            default: w_cond = 1'b1;
        endcase
    end

    assign w_taken = r_ir[DATA_W-1] && w_cond;

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_init:  w_next = c_st_idle;
            c_st_idle: begin
                if (run || (step && !r_step_d)) begin
                    w_next = c_st_fetch;
                end
            end
            c_st_fetch: begin
                if (rom_ack) begin
                    w_next = c_st_exec;
                end
            end
            c_st_exec: begin
                // A taken jump onto itself is the Hack end-of-program idiom.
                if (w_taken && (a_reg == pc_out)) begin
                    w_next = c_st_halt;
                end else if (run) begin
                    w_next = c_st_fetch;
                end else begin
                    w_next = c_st_idle;
                end
            end
            c_st_halt:  w_next = c_st_halt;
            default:    w_next = c_st_init;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_init;
            r_ir     <= '0;
            r_count  <= '0;
            r_step_d <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_step_d <= step;
            if ((r_state == c_st_fetch) && rom_ack) begin
                r_ir <= rom_data;
            end
            if (r_state == c_st_exec) begin
                r_count <= r_count + c_cnt_one;
            end
        end
    end

    // Strobes are gated by reset so they drop without waiting for a clock edge.
    assign w_active    = !reset;
    assign w_exec      = w_active && (r_state == c_st_exec);
    assign rom_req     = w_active && (r_state == c_st_fetch);
    assign exec_en     = w_exec;
    assign pc_reset    = w_active && (r_state == c_st_init);
    assign pc_load     = w_exec && w_taken;
    assign pc_inc      = w_exec && !w_taken;
    assign pc_in       = a_reg;
    assign busy        = (r_state != c_st_idle) && (r_state != c_st_halt);
    assign halted      = (r_state == c_st_halt);
    assign ir          = r_ir;
    assign instr_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_hack_pc_sequencer.sv
// ============================================================================
// Module      : tb_hack_pc_sequencer
// Description : Directed self-checking bench for hack_pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hack_pc_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        rom_req;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [14:0] pc_out;
    logic [14:0] a_reg;
    logic        alu_zr;
    logic        alu_ng;
    logic [15:0] ir;
    logic        exec_en;
    logic        pc_reset;
    logic        pc_load;
    logic        pc_inc;
    logic [14:0] pc_in;
    logic        busy;
    logic        halted;
    logic [15:0] instr_count;

    int checks;
    int failures;

    // Taken per jump code; bit2 = {zr=1,ng=0}, bit1 = {zr=0,ng=1}, bit0 = {zr=0,ng=0}.
    logic [2:0] taken_tbl [0:7];

    hack_pc_sequencer #(.ADDR_W(15), .DATA_W(16), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data),
        .pc_out(pc_out), .a_reg(a_reg), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .ir(ir), .exec_en(exec_en), .pc_reset(pc_reset), .pc_load(pc_load),
        .pc_inc(pc_inc), .pc_in(pc_in), .busy(busy), .halted(halted),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (pc_reset !== 1'b0 || rom_req !== 1'b0 || exec_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: pc_reset=%b rom_req=%b exec_en=%b required 0/0/0", pc_reset, rom_req, exec_en);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (pc_reset !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL init_pc_reset: pc_reset=%b busy=%b required 1/1", pc_reset, busy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (pc_reset !== 1'b0 || busy !== 1'b0 || instr_count !== 16'd0 || ir !== 16'h0000 || halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: pc_reset=%b busy=%b count=%0d ir=%h halted=%b required 0/0/0/0000/0",
                     pc_reset, busy, instr_count, ir, halted);
        end
    endtask

    task automatic test_free_run();
        run = 1'b1; rom_ack = 1'b1; rom_data = 16'h0005;
        @(negedge clk); #1;
        checks++;
        if (rom_req !== 1'b1 || exec_en !== 1'b0) begin
            failures++;
            $display("FAIL fr_fetch1: rom_req=%b exec_en=%b required 1/0", rom_req, exec_en);
        end
        @(negedge clk);
        rom_data = 16'h0007; #1;
        checks++;
        if (exec_en !== 1'b1 || pc_inc !== 1'b1 || pc_load !== 1'b0 || ir !== 16'h0005) begin
            failures++;
            $display("FAIL fr_exec1: exec_en=%b pc_inc=%b pc_load=%b ir=%h required 1/1/0/0005", exec_en, pc_inc, pc_load, ir);
        end
        @(negedge clk); #1;
        checks++;
        if (rom_req !== 1'b1 || exec_en !== 1'b0) begin
            failures++;
            $display("FAIL fr_fetch2: rom_req=%b exec_en=%b required 1/0", rom_req, exec_en);
        end
        @(negedge clk); #1;
        checks++;
        if (exec_en !== 1'b1 || pc_inc !== 1'b1 || ir !== 16'h0007) begin
            failures++;
            $display("FAIL fr_exec2: exec_en=%b pc_inc=%b ir=%h required 1/1/0007", exec_en, pc_inc, ir);
        end
        run = 1'b0; rom_ack = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (instr_count !== 16'd2 || busy !== 1'b0 || rom_req !== 1'b0) begin
            failures++;
            $display("FAIL fr_done: count=%0d busy=%b rom_req=%b required 2/0/0", instr_count, busy, rom_req);
        end
    endtask

    task automatic test_jump_table();
        logic exp_taken;
        a_reg = 15'h0010; pc_out = 15'h0004;
        for (int j = 0; j < 8; j++) begin
            for (int f = 0; f < 3; f++) begin
                alu_zr = (f == 0);
                alu_ng = (f == 1);
                exp_taken = taken_tbl[j][2-f];
                run = 1'b1; rom_ack = 1'b1; rom_data = 16'hE300 | 16'(j);
                @(negedge clk);
                run = 1'b0;
                @(negedge clk); #1;
                checks++;
                if (exec_en !== 1'b1 || pc_load !== exp_taken || pc_inc !== !exp_taken || pc_in !== 15'h0010) begin
                    failures++;
                    $display("FAIL jump j=%0d zr=%b ng=%b: exec_en=%b pc_load=%b pc_inc=%b pc_in=%h required 1/%b/%b/0010",
                             j, alu_zr, alu_ng, exec_en, pc_load, pc_inc, pc_in, exp_taken, !exp_taken);
                end
                rom_ack = 1'b0;
                @(negedge clk);
            end
        end
        #1;
        checks++;
        if (instr_count !== 16'd26 || busy !== 1'b0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL jump_done: count=%0d busy=%b halted=%b required 26/0/0", instr_count, busy, halted);
        end
    endtask

    task automatic test_stall_run_drop();
        int req_cycles;
        int exec_cycles;
        req_cycles = 0; exec_cycles = 0;
        alu_zr = 1'b0; alu_ng = 1'b0;
        run = 1'b1; rom_ack = 1'b0; rom_data = 16'h0003;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) run = 1'b0;
            if (c == 4) rom_ack = 1'b1;
            #1;
            if (rom_req === 1'b1) req_cycles++;
            if (exec_en === 1'b1) exec_cycles++;
        end
        @(negedge clk);
        rom_ack = 1'b0; #1;
        if (exec_en === 1'b1) exec_cycles++;
        @(negedge clk); #1;
        if (exec_en === 1'b1) exec_cycles++;
        checks++;
        if (req_cycles != 5 || exec_cycles != 1) begin
            failures++;
            $display("FAIL stall: rom_req cycles=%0d exec pulses=%0d required 5/1", req_cycles, exec_cycles);
        end
        checks++;
        if (busy !== 1'b0 || rom_req !== 1'b0 || instr_count !== 16'd27 || ir !== 16'h0003) begin
            failures++;
            $display("FAIL stall_idle: busy=%b rom_req=%b count=%0d ir=%h required 0/0/27/0003", busy, rom_req, instr_count, ir);
        end
    endtask

    task automatic test_single_step();
        int pulses;
        run = 1'b0; rom_ack = 1'b1; rom_data = 16'h0001;
        step = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            if (exec_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL step_held: exec pulses=%0d required 1", pulses);
        end
        step = 1'b0;
        repeat (2) @(negedge clk);
        step = 1'b1;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (exec_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL step_second: exec pulses=%0d required 1", pulses);
        end
        step = 1'b0;
        @(negedge clk);
        run = 1'b1;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 1) step = 1'b1;
            if (c == 5) begin
                run = 1'b0;
                step = 1'b0;
            end
            #1;
            if (exec_en === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 3) begin
            failures++;
            $display("FAIL step_with_run: exec pulses=%0d required 3", pulses);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || instr_count !== 16'd32) begin
            failures++;
            $display("FAIL step_done: busy=%b count=%0d required 0/32", busy, instr_count);
        end
        rom_ack = 1'b0;
    endtask

    task automatic test_halt();
        int reqs;
        a_reg = 15'h0012; pc_out = 15'h0012;
        alu_zr = 1'b1; alu_ng = 1'b0;
        run = 1'b1; rom_ack = 1'b1; rom_data = 16'hEA87;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (exec_en !== 1'b1 || pc_load !== 1'b1 || pc_inc !== 1'b0) begin
            failures++;
            $display("FAIL halt_exec: exec_en=%b pc_load=%b pc_inc=%b required 1/1/0", exec_en, pc_load, pc_inc);
        end
        reqs = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            step = c[0];
            #1;
            if (rom_req === 1'b1 || exec_en === 1'b1 || pc_inc === 1'b1 || pc_load === 1'b1 || halted !== 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0 || halted !== 1'b1 || busy !== 1'b0 || instr_count !== 16'd33) begin
            failures++;
            $display("FAIL halt_hold: bad cycles=%0d halted=%b busy=%b count=%0d required 0/1/0/33",
                     reqs, halted, busy, instr_count);
        end
        step = 1'b0; run = 1'b0; rom_ack = 1'b0;
    endtask

    task automatic test_async_reset_mid_fetch();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1; rom_ack = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (rom_req !== 1'b1 || halted !== 1'b0) begin
            failures++;
            $display("FAIL arst_fetch: rom_req=%b halted=%b required 1/0", rom_req, halted);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rom_req !== 1'b0 || exec_en !== 1'b0 || pc_reset !== 1'b0 || pc_load !== 1'b0 || pc_inc !== 1'b0) begin
            failures++;
            $display("FAIL arst_async: rom_req=%b exec_en=%b pc_reset=%b pc_load=%b pc_inc=%b required all 0",
                     rom_req, exec_en, pc_reset, pc_load, pc_inc);
        end
        checks++;
        if (ir !== 16'h0000 || instr_count !== 16'd0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL arst_regs: ir=%h count=%0d halted=%b required 0000/0/0", ir, instr_count, halted);
        end
        run = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rom_req !== 1'b0) begin
            failures++;
            $display("FAIL arst_recover: busy=%b rom_req=%b required 0/0", busy, rom_req);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        taken_tbl[0] = 3'b000; taken_tbl[1] = 3'b001;
        taken_tbl[2] = 3'b100; taken_tbl[3] = 3'b101;
        taken_tbl[4] = 3'b010; taken_tbl[5] = 3'b011;
        taken_tbl[6] = 3'b110; taken_tbl[7] = 3'b111;
        reset = 1'b1; run = 1'b0; step = 1'b0; rom_ack = 1'b0; rom_data = 16'h0000;
        pc_out = 15'h0000; a_reg = 15'h0000; alu_zr = 1'b0; alu_ng = 1'b0;

        test_reset();
        test_free_run();
        test_jump_table();
        test_stall_run_drop();
        test_single_step();
        test_halt();
        test_async_reset_mid_fetch();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
